// File: rtl/mat_mult_pkg.sv
// Shared types and width helpers for the sequential signed matrix multiplier.
// Holds the FSM state encoding and the default accumulator-width computation.
package mat_mult_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    // Index width for a counter over 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Full-precision accumulator: product width plus growth of an n-term sum.
    function automatic int acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mat_mult_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
// o_acc_next exposes the sum that the next enabled edge will store.
module mat_mult_mac
    import mat_mult_pkg::*;
#(
    parameter int DW   = 8,
    parameter int ACCW = 19
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic signed [ACCW-1:0] o_acc_next
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [ACCW-1:0] w_prod_ext;
    logic signed [ACCW-1:0] r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = ACCW'(w_prod);
    assign o_acc_next = r_acc + w_prod_ext;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// Sequential NxN signed matrix multiplier: stream A then B in, stream C = A x B out.
// Define MATMUL_SAT_EN to saturate (instead of wrap) results when OW < ACCW.
module mat_mult_seq
    import mat_mult_pkg::*;
#(
    parameter int N    = 8,
    parameter int DW   = 8,
    parameter int ACCW = acc_w(DW, N),
    parameter int OW   = ACCW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int IW = idx_w(N);
    localparam int LW = idx_w(NN);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [LW-1:0] LAST_LD  = LW'(NN - 1);

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((longint'(1) << (OW - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    state_t               r_state;
    logic                 r_in_ready;
    logic                 r_busy;
    logic                 r_out_valid;
    logic [OW-1:0]        r_out_data;
    logic                 r_out_last;
    logic [LW-1:0]        r_ld_cnt;
    logic [IW-1:0]        r_i;
    logic [IW-1:0]        r_j;
    logic [IW-1:0]        r_k;

    logic signed [DW-1:0] r_mat_a [NN];
    logic signed [DW-1:0] r_mat_b [NN];

    logic                 w_in_xfer;
    logic                 w_last_elem;
    logic                 w_mac_en;
    logic                 w_mac_clr;
    logic [LW-1:0]        w_a_addr;
    logic [LW-1:0]        w_b_addr;
    logic signed [DW-1:0] w_a;
    logic signed [DW-1:0] w_b;
    logic signed [ACCW-1:0] w_acc_next;

    function automatic logic [OW-1:0] fit_out(input logic signed [ACCW-1:0] v);
`ifdef MATMUL_SAT_EN
        if (v > SAT_MAX) return OW'(SAT_MAX);
        if (v < SAT_MIN) return OW'(SAT_MIN);
        return v[OW-1:0];
`else
        return v[OW-1:0];
`endif
    endfunction

    assign w_in_xfer   = in_valid && r_in_ready;
    assign w_last_elem = (r_i == LAST_IDX) && (r_j == LAST_IDX);
    assign w_mac_en    = (r_state == COMPUTE);
    assign w_mac_clr   = !w_mac_en;

    // A is walked along row i, B down column j; both stored row-major.
    assign w_a_addr = LW'(int'(r_i) * N + int'(r_k));
    assign w_b_addr = LW'(int'(r_k) * N + int'(r_j));
    assign w_a      = r_mat_a[w_a_addr];
    assign w_b      = r_mat_b[w_b_addr];

    // NOTE: matrix storage has no reset; a full load always rewrites every entry before COMPUTE reads it.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            if (r_state == LOAD_A) begin
                r_mat_a[r_ld_cnt] <= $signed(in_data);
            end else begin
                r_mat_b[r_ld_cnt] <= $signed(in_data);
            end
        end
    end

    mat_mult_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_mac_clr),
        .i_en       (w_mac_en),
        .i_a        (w_a),
        .i_b        (w_b),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_ld_cnt    <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= LOAD_A;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ld_cnt   <= '0;
                    end
                end
                LOAD_A: begin
                    if (w_in_xfer) begin
                        if (r_ld_cnt == LAST_LD) begin
                            r_ld_cnt <= '0;
                            r_state  <= LOAD_B;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + LW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (w_in_xfer) begin
                        if (r_ld_cnt == LAST_LD) begin
                            r_ld_cnt   <= '0;
                            r_state    <= COMPUTE;
                            r_in_ready <= 1'b0;
                            r_i        <= '0;
                            r_j        <= '0;
                            r_k        <= '0;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + LW'(1);
                        end
                    end
                end
                COMPUTE: begin
                    // The last product is folded in combinationally so the result registers with out_valid.
                    if (r_k == LAST_IDX) begin
                        r_k         <= '0;
                        r_state     <= DRAIN;
                        r_out_valid <= 1'b1;
                        r_out_data  <= fit_out(w_acc_next);
                        r_out_last  <= w_last_elem;
                    end else begin
                        r_k <= r_k + IW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (w_last_elem) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_i     <= '0;
                            r_j     <= '0;
                        end else begin
                            r_state <= COMPUTE;
                            if (r_j == LAST_IDX) begin
                                r_j <= '0;
                                r_i <= r_i + IW'(1);
                            end else begin
                                r_j <= r_j + IW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Bench for mat_mult_seq: a full-width (OW=19) and a narrowed (OW=16) instance run in lockstep.
// Narrow-output expectations follow MATMUL_SAT_EN when it is defined for the build.
module tb_mat_mult_seq;

    localparam int N    = 8;
    localparam int DW   = 8;
    localparam int OW   = 19;
    localparam int OW16 = 16;
    localparam int NN   = N * N;

    typedef enum int {P_CONST, P_IDENT, P_RAMP} pat_e;
    typedef enum int {R_ALWAYS, R_RANDOM, R_HOLD20} rdy_e;

    typedef struct {
        pat_e a_pat;
        int   a_val;
        pat_e b_pat;
        int   b_val;
        pat_e c_pat;     // P_RAMP: C[r][c] = r*N+c, else the constants below
        int   c19;
        int   c16_wrap;
        int   c16_sat;
        bit   gaps;
        bit   junk;
        rdy_e rdy;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            out_ready = 1'b1;
    logic            in_ready, out_valid, out_last, busy;
    logic [OW-1:0]   out_data;
    logic            in_ready16, out_valid16, out_last16, busy16;
    logic [OW16-1:0] out_data16;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    mat_mult_seq #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    mat_mult_seq #(.N(N), .DW(DW), .OW(OW16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .in_data(in_data), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_last(out_last16), .busy(busy16)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " out_last"}, out_last, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " in_ready16"}, in_ready16, 0);
        check({tag, " out_data16"}, out_data16, 0);
        check({tag, " busy16"}, busy16, 0);
    endtask

    function automatic int pat_val(input pat_e p, input int v, input int r, input int c);
        case (p)
            P_IDENT: return (r == c) ? 1 : 0;
            P_RAMP:  return r * N + c;
            default: return v;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int val);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = DW'(val);
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input vec_t v);
        for (int m = 0; m < 2; m++) begin
            for (int e = 0; e < NN; e++) begin
                if (v.gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
                if (m == 0) send(pat_val(v.a_pat, v.a_val, e / N, e % N));
                else        send(pat_val(v.b_pat, v.b_val, e / N, e % N));
            end
        end
    endtask

    task automatic collect(input int vi, input vec_t v, input int n);
        int              idx = 0;
        int              cyc = 0;
        int              hold = 0;
        bit              stalled = 1'b0;
        logic [OW-1:0]   pd = '0;
        logic [OW16-1:0] pd16 = '0;
        int              r, c, e19, e16;
        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check($sformatf("v%0d stall valid", vi), out_valid, 1);
                check($sformatf("v%0d stall data", vi), out_data, pd);
                check($sformatf("v%0d stall data16", vi), out_data16, pd16);
            end
            case (v.rdy)
                R_RANDOM: out_ready = 1'($urandom_range(0, 1));
                R_HOLD20: begin
                    out_ready = 1'b1;
                    if (idx == 0 && out_valid && hold < 20) begin
                        out_ready = 1'b0;
                        hold++;
                    end
                end
                default:  out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                r   = idx / N;
                c   = idx % N;
                e19 = (v.c_pat == P_RAMP) ? r * N + c : v.c19;
`ifdef MATMUL_SAT_EN
                e16 = (v.c_pat == P_RAMP) ? r * N + c : v.c16_sat;
`else
                e16 = (v.c_pat == P_RAMP) ? r * N + c : v.c16_wrap;
`endif
                check($sformatf("v%0d C[%0d][%0d]", vi, r, c), longint'($signed(out_data)), e19);
                check($sformatf("v%0d C16[%0d][%0d]", vi, r, c), longint'($signed(out_data16)), e16);
                check($sformatf("v%0d last[%0d][%0d]", vi, r, c), out_last, (idx == NN - 1) ? 1 : 0);
                check($sformatf("v%0d valid16[%0d][%0d]", vi, r, c), out_valid16, 1);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                pd      = out_data;
                pd16    = out_data16;
            end
        end
        if (idx < n) check($sformatf("v%0d collect timeout", vi), idx, n);
        out_ready = 1'b1;
    endtask

    task automatic run_vector(input int vi);
        vec_t v;
        int   cyc;
        v = vecs[vi];
        fork
            begin
                load(v);
                cyc = 0;
                if (v.junk) begin
                    in_valid = 1'b1;
                    in_data  = 8'h55;
                end
                while (busy && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                end
                in_valid = 1'b0;
                if (v.rdy == R_ALWAYS) check($sformatf("v%0d latency", vi), cyc, NN * (N + 1));
                else if (busy) check($sformatf("v%0d busy timeout", vi), busy, 0);
            end
            collect(vi, v, NN);
        join
    endtask

    initial begin
        // a_pat a_val b_pat b_val c_pat c19 c16_wrap c16_sat gaps junk rdy
        vecs[0] = '{P_IDENT, 0, P_RAMP, 0, P_RAMP, 0, 0, 0, 1'b0, 1'b0, R_ALWAYS};
        vecs[1] = '{P_CONST, -128, P_CONST, -128, P_CONST, 131072, 0, 32767, 1'b0, 1'b0, R_ALWAYS};
        vecs[2] = '{P_CONST, 1, P_CONST, 1, P_CONST, 8, 8, 8, 1'b0, 1'b1, R_ALWAYS};
        // 129032 keeps 0xF808 in 16 bits, i.e. -2040 when read as signed
        vecs[3] = '{P_CONST, 127, P_CONST, 127, P_CONST, 129032, -2040, 32767, 1'b0, 1'b0, R_ALWAYS};
        vecs[4] = '{P_CONST, -128, P_CONST, 127, P_CONST, -130048, 1024, -32768, 1'b0, 1'b0, R_ALWAYS};
        vecs[5] = '{P_IDENT, 0, P_RAMP, 0, P_RAMP, 0, 0, 0, 1'b1, 1'b0, R_ALWAYS};
        vecs[6] = '{P_IDENT, 0, P_RAMP, 0, P_RAMP, 0, 0, 0, 1'b0, 1'b0, R_RANDOM};
        vecs[7] = '{P_CONST, 2, P_CONST, -3, P_CONST, -48, -48, -48, 1'b0, 1'b0, R_HOLD20};

        #3 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("idle");

        for (int vi = 0; vi < 8; vi++) run_vector(vi);

        // Abort while C[3][4] is being accumulated, then reload from scratch.
        fork
            load(vecs[3]);
            collect(3, vecs[3], 3 * N + 4);
        join
        repeat (2) @(negedge clk);
        check("mid busy", busy, 1);
        check("mid out_valid", out_valid, 0);
        rst_n = 1'b0;
        #1 check_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vector(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
